// File: rtl/hack_rom_pkg.sv
// Shared definitions for the loadable Hack instruction memory.
//   hack_rom_state_e : loader FSM states (RUN = CPU fetching, others = loading)
//   LEN_BYTES        : size of the big-endian word-count field at the start of the stream
//   idx_width()      : index width of the word array, limited by the fetch address width
package hack_rom_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } hack_rom_state_e;

  localparam int LEN_BYTES = 2;

  function automatic int idx_width(input int addr_w, input int depth);
    int w;
    w = (depth > 1) ? $clog2(depth) : 1;
    return (w < addr_w) ? w : addr_w;
  endfunction

endpackage

// File: rtl/hack_rom_loadable_if.sv
// Internal memory bus between the loader/fetch controller and the word array.
//   we/waddr/wdata : write strobe, word index and data (one word per strobe)
//   re/raddr       : read enable and word index; rdata is registered and shows
//                    mem[raddr] one cycle after re, or zero when re was low.
// There is no flow control on this bus: a strobe is accepted on the clock edge
// where it is high; reads and writes are never issued in the same cycle.
// Modports: master = controller, slave = memory.
interface hack_rom_loadable_if #(
  parameter int IDX_W  = 15,
  parameter int DATA_W = 16
);
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [IDX_W-1:0]  raddr;
  logic [DATA_W-1:0] rdata;

  modport master (output we, waddr, wdata, re, raddr, input rdata);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/hack_rom_mem.sv
// Single-port synchronous word memory with a registered read port.
//   clock, reset : rising-edge clock; async active-high reset clears only the read register
//   bus          : slave side of hack_rom_loadable_if (write strobe, read enable, rdata)
// The array itself is never reset; its contents survive reset.
module hack_rom_mem
  import hack_rom_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768,
  parameter int DATA_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  hack_rom_loadable_if.slave bus
);

  localparam int IDX_W = idx_width(ADDR_W, DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clock) begin
    if (bus.we) mem[bus.waddr] <= bus.wdata;
  end

  // A disabled read returns zero so the fetch port is clean outside RUN.
  always_comb begin
    rdata_d = '0;
    if (bus.re) rdata_d = mem[bus.raddr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: rtl/hack_rom_loadable.sv
// Hack instruction memory loaded at run time from a byte stream.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   addr, out    : CPU fetch; out is mem[addr] one cycle later (zero if addr >= DEPTH or loading)
//   load_start   : pulse in RUN starts a load (ignored while loading)
//   in_data/in_valid/in_ready : byte loader; a byte moves when in_valid && in_ready
//   cpu_hold     : high while a load is in progress (holds the CPU in reset)
//   load_done    : one-cycle pulse in the first RUN cycle after a load
//   load_err     : sticky; N > DEPTH or checksum mismatch; cleared by the next load_start
//   state_dbg    : current loader state
// Stream: LEN (2 bytes, big-endian word count N), N words big-endian,
// then a DATA_W checksum when HACK_ROM_CSUM_EN is defined.
module hack_rom_loadable
  import hack_rom_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output hack_rom_state_e   state_dbg
);

  localparam int              BYTES    = DATA_W / 8;
  localparam int              IDX_W    = idx_width(ADDR_W, DEPTH);
  localparam int              ASM_W    = (DATA_W > 8) ? DATA_W - 8 : 1;
  localparam logic [7:0]      LAST_B   = 8'(BYTES - 1);
  localparam logic [7:0]      LAST_LEN = 8'(LEN_BYTES - 1);
  localparam logic [16:0]     DEPTH_N  = 17'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  hack_rom_state_e   state_d, state_q;
  logic [7:0]        cnt_d, cnt_q;      // byte position inside the current field/word
  logic [15:0]       idx_d, idx_q;      // index of the word being assembled
  logic [15:0]       len_d, len_q;      // word count N
  logic [ASM_W-1:0]  asm_d, asm_q;      // earlier bytes of the word being assembled
  logic              err_d, err_q;
  logic              done_d, done_q;
`ifdef HACK_ROM_CSUM_EN
  logic [DATA_W-1:0] sum_d, sum_q;
`endif

  logic              accept;
  logic              mem_we;
  logic [15:0]       len_asm;
  logic [DATA_W-1:0] word_asm;
  logic [ASM_W-1:0]  asm_next;

  hack_rom_loadable_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) mem_bus ();

  hack_rom_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clock (clock),
    .reset (reset),
    .bus   (mem_bus.slave)
  );

  assign in_ready = (state_q != RUN);
  assign cpu_hold = (state_q != RUN);
  assign accept   = in_valid && in_ready;
  assign len_asm  = {len_q[7:0], in_data};

  // word_asm is the complete word if in_data is its final byte.
  if (DATA_W > 8) begin : g_wide
    assign word_asm = {asm_q, in_data};
    assign asm_next = word_asm[ASM_W-1:0];
  end else begin : g_byte
    assign word_asm = in_data;
    assign asm_next = asm_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    asm_d   = asm_q;
    err_d   = err_q;
    mem_we  = 1'b0;
`ifdef HACK_ROM_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      RUN: begin
        if (load_start) begin
          state_d = LEN;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
`ifdef HACK_ROM_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          len_d = len_asm;
          if (cnt_q == LAST_LEN) begin
            cnt_d = '0;
            if ({1'b0, len_asm} > DEPTH_N) err_d = 1'b1;
`ifdef HACK_ROM_CSUM_EN
            state_d = (len_asm != 16'd0) ? DATA : CSUM;
`else
            state_d = (len_asm != 16'd0) ? DATA : RUN;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d = asm_next;
          if (cnt_q == LAST_B) begin
            cnt_d = '0;
            // Words past DEPTH are consumed but dropped.
            mem_we = ({1'b0, idx_q} < DEPTH_N);
            idx_d  = idx_q + 16'd1;
`ifdef HACK_ROM_CSUM_EN
            sum_d = sum_q + word_asm;
            if (idx_q == len_q - 16'd1) state_d = CSUM;
`else
            if (idx_q == len_q - 16'd1) state_d = RUN;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      CSUM: begin
`ifdef HACK_ROM_CSUM_EN
        if (accept) begin
          asm_d = asm_next;
          if (cnt_q == LAST_B) begin
            cnt_d   = '0;
            state_d = RUN;
            if (word_asm != sum_q) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`else
        state_d = RUN;
`endif
      end
      default: state_d = RUN;
    endcase
    done_d = (state_q != RUN) && (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef HACK_ROM_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef HACK_ROM_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_bus.we    = mem_we;
  assign mem_bus.waddr = idx_q[IDX_W-1:0];
  assign mem_bus.wdata = word_asm;
  assign mem_bus.re    = (state_q == RUN) && ({1'b0, addr} < DEPTH_A);
  assign mem_bus.raddr = addr[IDX_W-1:0];

  assign out       = mem_bus.rdata;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign state_dbg = state_q;

endmodule
